// File: rtl/tlb_xlate_check_pkg.sv
// Shared TLB translate-check definitions: exception codes, access types, page sizes
// and the exception priority function used by every lookup port.
package tlb_xlate_check_pkg;

  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_PPI  = 6'h07;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_2M = 6'd21;

  typedef enum logic [1:0] {
    MEM_FETCH = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_type_e;

  typedef struct packed {
    logic       exc;
    logic [5:0] ecode;
  } xlate_chk_t;

  // First matching condition wins; encoding 3 of mem_type behaves as a load.
  function automatic xlate_chk_t xlate_check(input logic       hit,
                                             input logic       v,
                                             input logic       d,
                                             input logic [1:0] mem_type,
                                             input logic [1:0] csr_plv,
                                             input logic [1:0] plv);
    xlate_chk_t r;
    r.exc   = 1'b1;
    r.ecode = ECODE_TLBR;
    if (!hit) begin
      r.ecode = ECODE_TLBR;
    end else if (!v) begin
      case (mem_type)
        MEM_FETCH: r.ecode = ECODE_PIF;
        MEM_STORE: r.ecode = ECODE_PIS;
        default:   r.ecode = ECODE_PIL;
      endcase
    end else if (csr_plv > plv) begin
      r.ecode = ECODE_PPI;
    end else if ((mem_type == MEM_STORE) && !d) begin
      r.ecode = ECODE_PME;
    end else begin
      r.exc   = 1'b0;
      r.ecode = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_xlate_check_slice.sv
// One lookup port: valid/ready register slice plus V/PLV/D check and PA build.
// TLB_XLATE_PERF_EN adds per-port hit/miss counters on accepted lookups.
module tlb_xlate_slice
  import tlb_xlate_check_pkg::*;
#(
  parameter int unsigned PALEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [1:0]       csr_plv_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      va_i,
  input  logic [1:0]       mem_type_i,
  input  logic             hit_i,
  input  logic [5:0]       ps_i,
  input  logic             found_v_i,
  input  logic             found_d_i,
  input  logic [1:0]       found_mat_i,
  input  logic [1:0]       found_plv_i,
  input  logic [PALEN-13:0] found_pfn_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PALEN-1:0] pa_o,
  output logic [1:0]       mat_o,
  output logic             exc_o,
  output logic [5:0]       ecode_o,
  output logic [31:0]      badv_o
`ifdef TLB_XLATE_PERF_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o
`endif
);

  logic             valid_q;
  logic [PALEN-1:0] pa_q, pa_d;
  logic [1:0]       mat_q, mat_d;
  logic             exc_q;
  logic [5:0]       ecode_q;
  logic [31:0]      badv_q;
  xlate_chk_t       chk_d;
  logic             accept;

  assign in_ready_o = !valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_comb begin
    chk_d = xlate_check(hit_i, found_v_i, found_d_i, mem_type_i, csr_plv_i, found_plv_i);
    pa_d  = '0;
    mat_d = '0;
    if (!chk_d.exc) begin
      mat_d = found_mat_i;
      // Only 2M pages replace the low PFN bits with VA; every other size acts as 4K.
      if (ps_i == PS_2M) pa_d = {found_pfn_i[PALEN-13:9], va_i[20:0]};
      else               pa_d = {found_pfn_i, va_i[11:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pa_q    <= '0;
      mat_q   <= '0;
      exc_q   <= 1'b0;
      ecode_q <= '0;
      badv_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pa_q    <= pa_d;
      mat_q   <= mat_d;
      exc_q   <= chk_d.exc;
      ecode_q <= chk_d.ecode;
      badv_q  <= va_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid_o = valid_q;
  assign pa_o        = pa_q;
  assign mat_o       = mat_q;
  assign exc_o       = exc_q;
  assign ecode_o     = ecode_q;
  assign badv_o      = badv_q;

`ifdef TLB_XLATE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (hit_i) hit_cnt_q  <= hit_cnt_q + 32'd1;
      else       miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: rtl/tlb_xlate_check.sv
// TLB translate-check stage: two independent slices (0 = fetch, 1 = data).
// Optional TLB_XLATE_PERF_EN exposes per-port hit/miss counters.
module tlb_xlate_check
  import tlb_xlate_check_pkg::*;
#(
  parameter int unsigned PALEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       csr_plv,
  input  logic             in_valid0,
  input  logic             in_valid1,
  output logic             in_ready0,
  output logic             in_ready1,
  input  logic [31:0]      va0,
  input  logic [31:0]      va1,
  input  logic [1:0]       mem_type0,
  input  logic [1:0]       mem_type1,
  input  logic             hit0,
  input  logic             hit1,
  input  logic [5:0]       ps0,
  input  logic [5:0]       ps1,
  input  logic             found_v0,
  input  logic             found_v1,
  input  logic             found_d0,
  input  logic             found_d1,
  input  logic [1:0]       found_mat0,
  input  logic [1:0]       found_mat1,
  input  logic [1:0]       found_plv0,
  input  logic [1:0]       found_plv1,
  input  logic [PALEN-13:0] found_pfn0,
  input  logic [PALEN-13:0] found_pfn1,
  output logic             out_valid0,
  output logic             out_valid1,
  input  logic             out_ready0,
  input  logic             out_ready1,
  output logic [PALEN-1:0] pa0,
  output logic [PALEN-1:0] pa1,
  output logic [1:0]       mat0,
  output logic [1:0]       mat1,
  output logic             exc0,
  output logic             exc1,
  output logic [5:0]       ecode0,
  output logic [5:0]       ecode1,
  output logic [31:0]      badv0,
  output logic [31:0]      badv1
`ifdef TLB_XLATE_PERF_EN
  ,
  output logic [31:0]      hit_cnt0,
  output logic [31:0]      hit_cnt1,
  output logic [31:0]      miss_cnt0,
  output logic [31:0]      miss_cnt1
`endif
);

  tlb_xlate_slice #(.PALEN(PALEN)) u_port0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .csr_plv_i   (csr_plv),
    .in_valid_i  (in_valid0),
    .in_ready_o  (in_ready0),
    .va_i        (va0),
    .mem_type_i  (mem_type0),
    .hit_i       (hit0),
    .ps_i        (ps0),
    .found_v_i   (found_v0),
    .found_d_i   (found_d0),
    .found_mat_i (found_mat0),
    .found_plv_i (found_plv0),
    .found_pfn_i (found_pfn0),
    .out_valid_o (out_valid0),
    .out_ready_i (out_ready0),
    .pa_o        (pa0),
    .mat_o       (mat0),
    .exc_o       (exc0),
    .ecode_o     (ecode0),
    .badv_o      (badv0)
`ifdef TLB_XLATE_PERF_EN
    ,
    .hit_cnt_o   (hit_cnt0),
    .miss_cnt_o  (miss_cnt0)
`endif
  );

  tlb_xlate_slice #(.PALEN(PALEN)) u_port1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .csr_plv_i   (csr_plv),
    .in_valid_i  (in_valid1),
    .in_ready_o  (in_ready1),
    .va_i        (va1),
    .mem_type_i  (mem_type1),
    .hit_i       (hit1),
    .ps_i        (ps1),
    .found_v_i   (found_v1),
    .found_d_i   (found_d1),
    .found_mat_i (found_mat1),
    .found_plv_i (found_plv1),
    .found_pfn_i (found_pfn1),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready1),
    .pa_o        (pa1),
    .mat_o       (mat1),
    .exc_o       (exc1),
    .ecode_o     (ecode1),
    .badv_o      (badv1)
`ifdef TLB_XLATE_PERF_EN
    ,
    .hit_cnt_o   (hit_cnt1),
    .miss_cnt_o  (miss_cnt1)
`endif
  );

endmodule

// File: tb/tb_tlb_xlate_check.sv
// Self-checking bench for tlb_xlate_check: per-port scoreboard plus directed scenario tasks.
module tb_tlb_xlate_check;

  typedef struct packed {
    logic [31:0] pa;
    logic [1:0]  mat;
    logic        exc;
    logic [5:0]  ecode;
    logic [31:0] badv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  csr_plv;
  logic [1:0]  in_valid, in_ready, out_valid, out_ready, hit, fv, fd, exc;
  logic [31:0] va    [2];
  logic [1:0]  mt    [2];
  logic [5:0]  ps    [2];
  logic [1:0]  fmat  [2];
  logic [1:0]  fplv  [2];
  logic [19:0] pfn   [2];
  logic [31:0] pa    [2];
  logic [1:0]  mat   [2];
  logic [5:0]  ecode [2];
  logic [31:0] badv  [2];
`ifdef TLB_XLATE_PERF_EN
  logic [31:0] hit_cnt  [2];
  logic [31:0] miss_cnt [2];
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tlb_xlate_check #(.PALEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .csr_plv    (csr_plv),
    .in_valid0  (in_valid[0]),
    .in_valid1  (in_valid[1]),
    .in_ready0  (in_ready[0]),
    .in_ready1  (in_ready[1]),
    .va0        (va[0]),
    .va1        (va[1]),
    .mem_type0  (mt[0]),
    .mem_type1  (mt[1]),
    .hit0       (hit[0]),
    .hit1       (hit[1]),
    .ps0        (ps[0]),
    .ps1        (ps[1]),
    .found_v0   (fv[0]),
    .found_v1   (fv[1]),
    .found_d0   (fd[0]),
    .found_d1   (fd[1]),
    .found_mat0 (fmat[0]),
    .found_mat1 (fmat[1]),
    .found_plv0 (fplv[0]),
    .found_plv1 (fplv[1]),
    .found_pfn0 (pfn[0]),
    .found_pfn1 (pfn[1]),
    .out_valid0 (out_valid[0]),
    .out_valid1 (out_valid[1]),
    .out_ready0 (out_ready[0]),
    .out_ready1 (out_ready[1]),
    .pa0        (pa[0]),
    .pa1        (pa[1]),
    .mat0       (mat[0]),
    .mat1       (mat[1]),
    .exc0       (exc[0]),
    .exc1       (exc[1]),
    .ecode0     (ecode[0]),
    .ecode1     (ecode[1]),
    .badv0      (badv[0]),
    .badv1      (badv[1])
`ifdef TLB_XLATE_PERF_EN
    ,
    .hit_cnt0   (hit_cnt[0]),
    .hit_cnt1   (hit_cnt[1]),
    .miss_cnt0  (miss_cnt[0]),
    .miss_cnt1  (miss_cnt[1])
`endif
  );

  // Reference translation written from the architectural rules, not the RTL structure.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] m, input logic h,
                                 input logic [5:0] s, input logic vb, input logic db,
                                 input logic [1:0] mt_a, input logic [1:0] pl,
                                 input logic [19:0] pf, input logic [1:0] cpl);
    exp_t e;
    logic [31:0] base;
    e.badv = a; e.exc = 1'b1; e.pa = 32'h0; e.mat = 2'd0; e.ecode = 6'h00;
    base = {12'h000, pf} << 12;
    if (!h)                   e.ecode = 6'h3F;
    else if (!vb)             e.ecode = (m == 2'd0) ? 6'h03 : (m == 2'd2) ? 6'h02 : 6'h01;
    else if (cpl > pl)        e.ecode = 6'h07;
    else if (m == 2'd2 && !db) e.ecode = 6'h04;
    else begin
      e.exc = 1'b0;
      e.mat = mt_a;
      if (s == 6'd21) e.pa = (base & 32'hFFE0_0000) | (a & 32'h001F_FFFF);
      else            e.pa = base | (a & 32'h0000_0FFF);
    end
    return e;
  endfunction

  for (genvar p = 0; p < 2; p++) begin : g_sb
    exp_t        sb[$];
    bit          mvalid = 1'b0;
    logic [31:0] mhit = 32'd0;
    logic [31:0] mmiss = 32'd0;
    logic        acc;

    assign acc = in_valid[p] && (!mvalid || out_ready[p]) && !flush && !rst;

    always @(posedge clk) begin
      if (rst) begin
        sb.delete();
        mvalid <= 1'b0;
        mhit   <= 32'd0;
        mmiss  <= 32'd0;
      end else if (flush) begin
        sb.delete();
        mvalid <= 1'b0;
      end else begin
        if (mvalid && out_ready[p] && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
          sb.push_back(model(va[p], mt[p], hit[p], ps[p], fv[p], fd[p], fmat[p], fplv[p], pfn[p], csr_plv));
          if (hit[p]) mhit  <= mhit + 32'd1;
          else        mmiss <= mmiss + 32'd1;
        end
        mvalid <= acc || (mvalid && !out_ready[p]);
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        checks++;
        if (out_valid[p] !== mvalid) begin
          errors++;
          $display("FAIL port%0d out_valid: got %b expected %b", p, out_valid[p], mvalid);
        end
        checks++;
        if (in_ready[p] !== (!mvalid || out_ready[p])) begin
          errors++;
          $display("FAIL port%0d in_ready: got %b expected %b", p, in_ready[p], !mvalid || out_ready[p]);
        end
        if (mvalid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL port%0d scoreboard empty while result expected", p);
          end else if ({pa[p], mat[p], exc[p], ecode[p], badv[p]} !== sb[0]) begin
            errors++;
            $display("FAIL port%0d result: got pa=%h mat=%0d exc=%b ecode=%h badv=%h expected pa=%h mat=%0d exc=%b ecode=%h badv=%h",
                     p, pa[p], mat[p], exc[p], ecode[p], badv[p],
                     sb[0].pa, sb[0].mat, sb[0].exc, sb[0].ecode, sb[0].badv);
          end
        end
`ifdef TLB_XLATE_PERF_EN
        checks++;
        if (hit_cnt[p] !== mhit || miss_cnt[p] !== mmiss) begin
          errors++;
          $display("FAIL port%0d counters: got hit=%0d miss=%0d expected hit=%0d miss=%0d",
                   p, hit_cnt[p], miss_cnt[p], mhit, mmiss);
        end
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic vld, input logic [31:0] a, input logic [1:0] m,
                        input logic h, input logic [5:0] s, input logic vb, input logic db,
                        input logic [1:0] mt_a, input logic [1:0] pl, input logic [19:0] pf);
    in_valid[p] = vld; va[p] = a; mt[p] = m; hit[p] = h; ps[p] = s;
    fv[p] = vb; fd[p] = db; fmat[p] = mt_a; fplv[p] = pl; pfn[p] = pf;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) set_in(p, 1'b0, 32'h0, 2'd0, 1'b0, 6'd12, 1'b0, 1'b0, 2'd0, 2'd0, 20'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; csr_plv = 2'd0; out_ready = 2'b11;
    idle_inputs();
    step(); step();
    for (int p = 0; p < 2; p++) begin
      checks++;
      if ({out_valid[p], pa[p], mat[p], exc[p], ecode[p], badv[p]} !== '0) begin
        errors++;
        $display("FAIL reset port%0d: got valid=%b pa=%h mat=%0d exc=%b ecode=%h badv=%h expected all zero",
                 p, out_valid[p], pa[p], mat[p], exc[p], ecode[p], badv[p]);
      end
    end
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    checks++;
    if (in_ready !== 2'b11) begin
      errors++;
      $display("FAIL reset in_ready: got %b expected 11", in_ready);
    end
  endtask

  task automatic test_translate();
    csr_plv = 2'd3;
    set_in(0, 1'b1, 32'h0000_0ABC, 2'd0, 1'b1, 6'd12, 1'b1, 1'b0, 2'd1, 2'd3, 20'h12345);
    step();
    in_valid[0] = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b1 || pa[0] !== 32'h1234_5ABC || exc[0] !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hit: got valid=%b pa=%h exc=%b expected 1 12345abc 0", out_valid[0], pa[0], exc[0]);
    end
    set_in(1, 1'b1, 32'h8000_1234, 2'd2, 1'b1, 6'd12, 1'b1, 1'b0, 2'd1, 2'd3, 20'h00777);
    step();
    checks++;
    if (exc[1] !== 1'b1 || ecode[1] !== 6'h04 || badv[1] !== 32'h8000_1234) begin
      errors++;
      $display("FAIL store_pme: got exc=%b ecode=%h badv=%h expected 1 04 80001234", exc[1], ecode[1], badv[1]);
    end
    hit[1] = 1'b0;
    step();
    checks++;
    if (exc[1] !== 1'b1 || ecode[1] !== 6'h3F) begin
      errors++;
      $display("FAIL store_tlbr: got exc=%b ecode=%h expected 1 3f", exc[1], ecode[1]);
    end
    set_in(1, 1'b1, 32'h0040_0010, 2'd1, 1'b1, 6'd12, 1'b0, 1'b1, 2'd1, 2'd3, 20'h00040);
    set_in(0, 1'b1, 32'h0040_0020, 2'd0, 1'b1, 6'd12, 1'b0, 1'b1, 2'd1, 2'd3, 20'h00040);
    step();
    checks++;
    if (ecode[1] !== 6'h01 || ecode[0] !== 6'h03) begin
      errors++;
      $display("FAIL pil_pif: got ecode1=%h ecode0=%h expected 01 03", ecode[1], ecode[0]);
    end
    set_in(0, 1'b1, 32'h0040_0030, 2'd1, 1'b1, 6'd12, 1'b1, 1'b1, 2'd1, 2'd0, 20'h00040);
    set_in(1, 1'b1, 32'h0050_0000, 2'd3, 1'b1, 6'd12, 1'b0, 1'b1, 2'd1, 2'd3, 20'h00040);
    step();
    checks++;
    if (ecode[0] !== 6'h07 || pa[0] !== 32'h0 || mat[0] !== 2'd0 || ecode[1] !== 6'h01) begin
      errors++;
      $display("FAIL ppi_type3: got ecode0=%h pa0=%h mat0=%0d ecode1=%h expected 07 0 0 01", ecode[0], pa[0], mat[0], ecode[1]);
    end
    // pfn[19:9] = 5 lands in PA[31:21], VA supplies PA[20:0].
    set_in(0, 1'b1, 32'h001F_FFFF, 2'd1, 1'b1, 6'd21, 1'b1, 1'b0, 2'd2, 2'd3, 20'h00A00);
    set_in(1, 1'b1, 32'hFFFF_F123, 2'd2, 1'b1, 6'd16, 1'b1, 1'b1, 2'd3, 2'd3, 20'hABCDE);
    step();
    checks++;
    if (pa[0] !== 32'h00BF_FFFF || mat[0] !== 2'd2 || pa[1] !== 32'hABCD_E123 || exc[1] !== 1'b0) begin
      errors++;
      $display("FAIL page_size: got pa0=%h mat0=%0d pa1=%h exc1=%b expected 00bfffff 2 abcde123 0", pa[0], mat[0], pa[1], exc[1]);
    end
    in_valid = 2'b00;
    step();
  endtask

  task automatic test_stall();
    csr_plv = 2'd0;
    out_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, 32'h1000_0000 + 32'(i) * 32'h1004, 2'd0, 1'b1, 6'd12, 1'b1, 1'b1, 2'd1, 2'd0, 20'h11111 + 20'(i));
      set_in(1, 1'b1, 32'h4000_0000 + 32'(i) * 32'h10, 2'd1, 1'b1, 6'd12, 1'b1, 1'b1, 2'd2, 2'd0, 20'h22222 + 20'(i));
      step();
    end
    checks++;
    if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || badv[1] !== 32'h4000_0000 || pa[1] !== 32'h2222_2000) begin
      errors++;
      $display("FAIL stall_hold: got ready1=%b valid1=%b badv1=%h pa1=%h expected 0 1 40000000 22222000",
               in_ready[1], out_valid[1], badv[1], pa[1]);
    end
    checks++;
    if (out_valid[0] !== 1'b1 || badv[0] !== 32'h1000_300C) begin
      errors++;
      $display("FAIL stall_stream0: got valid0=%b badv0=%h expected 1 1000300c", out_valid[0], badv[0]);
    end
    out_ready = 2'b11;
    in_valid  = 2'b00;
    step(); step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      csr_plv = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        logic [5:0] s;
        case ($urandom_range(0, 2))
          0:       s = 6'd12;
          1:       s = 6'd21;
          default: s = 6'd14;
        endcase
        set_in(p, 1'($urandom_range(0, 3) != 0), $urandom(), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 7) != 0), s, 1'($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               20'($urandom()));
        out_ready[p] = 1'($urandom_range(0, 3) != 0);
      end
      step();
    end
    in_valid  = 2'b00;
    out_ready = 2'b11;
    step(); step();
  endtask

  task automatic test_flush();
    csr_plv = 2'd0;
    out_ready = 2'b10;
    set_in(1, 1'b1, 32'h0000_5000, 2'd1, 1'b1, 6'd12, 1'b1, 1'b1, 2'd1, 2'd0, 20'h00005);
    set_in(0, 1'b1, 32'h0000_6000, 2'd1, 1'b1, 6'd12, 1'b1, 1'b1, 2'd1, 2'd0, 20'h00006);
    out_ready[1] = 1'b0;
    step();
    in_valid[1] = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 2'b00;
    checks++;
    if (out_valid !== 2'b00) begin
      errors++;
      $display("FAIL flush: got out_valid=%b expected 00", out_valid);
    end
    out_ready = 2'b11;
    step();
  endtask

`ifdef TLB_XLATE_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    csr_plv = 2'd0;
    out_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, 32'h0000_7000 + 32'(i), 2'd1, 1'(i != 2), 6'd12, 1'b1, 1'b1, 2'd1, 2'd0, 20'h00007);
      step();
    end
    flush = 1'b1;
    hit[0] = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 2'b00;
    checks++;
    if (hit_cnt[0] !== 32'd3 || miss_cnt[0] !== 32'd1) begin
      errors++;
      $display("FAIL perf_counters: got hit=%0d miss=%0d expected 3 1", hit_cnt[0], miss_cnt[0]);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_translate();
    test_stall();
    test_back_to_back();
    test_flush();
`ifdef TLB_XLATE_PERF_EN
    test_perf();
`endif
    step(); step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
